// File: rtl/lcd1602_bus_responder.sv
// lcd1602_bus_responder: HD44780 bus responder mirroring DDRAM; `LCD_BUSY_READ_EN adds busy/data read-back
module lcd1602_bus_responder #(
    parameter int          NUM_COLS    = 16,
    parameter logic [7:0]  BLANK_CHAR  = 8'h20,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] addr_counter,
    output logic       entry_inc,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       overrun,
    output logic       bad_addr
`ifdef LCD_BUSY_READ_EN
    ,
    output logic [7:0] lcd_dout,
    output logic       lcd_dout_oe
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;
    localparam logic [4:0] LAST = 5'(2 * NUM_COLS - 1);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [7:0]             r_mem [0:2*NUM_COLS-1];
    logic [4:0]             r_idx;
    logic                   r_rs;
    logic [7:0]             r_data;
    logic                   w_fall, w_take, w_ovr, w_ac_ok;
    logic [4:0]             w_wr_idx;

    // HD44780 AC stepping: the two 16-char lines wrap into each other
    function automatic logic [6:0] f_step(input logic [6:0] ac, input logic up);
        return up ? (ac == 7'h0F ? 7'h40 : ac == 7'h4F ? 7'h00 : ac + 7'd1)
                  : (ac == 7'h00 ? 7'h4F : ac == 7'h40 ? 7'h0F : ac - 7'd1);
    endfunction

    assign w_fall   = r_hist & ~r_sync[SYNC_STAGES-1];
    assign w_wr_idx = {addr_counter[6], addr_counter[3:0]};
    assign w_ac_ok  = addr_counter[5:4] == 2'b00;
`ifdef LCD_BUSY_READ_EN
    logic r_rw, r_bf;
    assign w_take = w_fall && r_state == IDLE && !(lcd_rw && !lcd_rs);
    assign w_ovr  = w_fall && r_state != IDLE && !(lcd_rw && !lcd_rs);
`else
    assign w_take = w_fall && r_state == IDLE && !lcd_rw;
    assign w_ovr  = w_fall && r_state != IDLE && !lcd_rw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync       <= '0;
            r_hist       <= 1'b0;
            r_state      <= CLEAR;
            r_idx        <= '0;
            r_rs         <= 1'b0;
            r_data       <= '0;
            addr_counter <= '0;
            entry_inc    <= 1'b1;
            display_on   <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            busy         <= 1'b1;
            cmd_strobe   <= 1'b0;
            overrun      <= 1'b0;
            bad_addr     <= 1'b0;
            rd_char      <= BLANK_CHAR;
`ifdef LCD_BUSY_READ_EN
            r_rw         <= 1'b0;
            r_bf         <= 1'b0;
            lcd_dout     <= '0;
            lcd_dout_oe  <= 1'b0;
`endif
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], lcd_en};
            r_hist     <= r_sync[SYNC_STAGES-1];
            rd_char    <= r_mem[rd_addr];
            cmd_strobe <= 1'b0;
            if (w_ovr) overrun <= 1'b1;
`ifdef LCD_BUSY_READ_EN
            r_bf <= w_fall && lcd_rw && !lcd_rs;
            if (w_fall) lcd_dout_oe <= 1'b0;
            if (r_bf) begin
                lcd_dout    <= {busy, addr_counter};
                lcd_dout_oe <= 1'b1;
            end
`endif
            case (r_state)
                IDLE: if (w_take) begin
                    r_rs    <= lcd_rs;
                    r_data  <= lcd_data;
                    r_state <= EXEC;
`ifdef LCD_BUSY_READ_EN
                    r_rw    <= lcd_rw;
`endif
                end
                EXEC: begin
                    cmd_strobe <= 1'b1;
                    r_state    <= IDLE;
                    if (r_rs) begin
`ifdef LCD_BUSY_READ_EN
                        if (r_rw) begin
                            lcd_dout     <= r_mem[w_wr_idx];
                            lcd_dout_oe  <= 1'b1;
                            addr_counter <= f_step(addr_counter, entry_inc);
                        end else
`endif
                        if (w_ac_ok) begin
                            r_mem[w_wr_idx] <= r_data;
                            addr_counter    <= f_step(addr_counter, entry_inc);
                        end
                    end else if (r_data[7]) begin
                        addr_counter <= r_data[6:0];
                        if (r_data[5:4] != 2'b00) bad_addr <= 1'b1;
                    end else if (r_data[6:5] == 2'b00) begin
                        if (r_data[4]) begin
                            if (!r_data[3]) addr_counter <= f_step(addr_counter, r_data[2]);
                        end else if (r_data[3]) {display_on, cursor_on, blink_on} <= r_data[2:0];
                        else if (r_data[2]) entry_inc <= r_data[1];
                        else if (r_data[1]) addr_counter <= '0;
                        else if (r_data[0]) begin
                            addr_counter <= '0;
                            entry_inc    <= 1'b1;
                            r_idx        <= '0;
                            busy         <= 1'b1;
                            r_state      <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    r_mem[r_idx] <= BLANK_CHAR;
                    r_idx        <= r_idx + 5'd1;
                    if (r_idx == LAST) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd1602_bus_responder.sv
// tb_lcd1602_bus_responder: randomized bus traffic checked against a position-based DDRAM model
module tb_lcd1602_bus_responder;
    logic       clk = 1'b0, reset = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_data = '0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_char;
    logic [6:0] addr_counter;
    logic       entry_inc, display_on, cursor_on, blink_on, busy, cmd_strobe, overrun, bad_addr;

    lcd1602_bus_responder dut (
        .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .addr_counter(addr_counter),
        .entry_inc(entry_inc), .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .busy(busy), .cmd_strobe(cmd_strobe), .overrun(overrun), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, n_strobe = 0, run = 0, last_run = 0;

    always @(negedge clk) begin
        if (cmd_strobe) n_strobe++;
        if (reset) run = 0;
        else if (busy) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    logic [7:0] m_mem [32];
    logic [6:0] m_ac;
    logic       m_inc, m_d, m_c, m_b, m_bad, m_ovr;

    function automatic bit in_rng(input logic [6:0] a);
        return a < 16 || (a >= 64 && a < 80);
    endfunction

    function automatic int pos(input logic [6:0] a);
        return (a >= 64 ? 16 : 0) + int'(a) % 16;
    endfunction

    // Cursor as a linear position 0..31 over both lines, mapped back to DDRAM addresses
    function automatic logic [6:0] m_step(input logic [6:0] a, input bit up);
        int p;
        if (!in_rng(a)) return up ? a + 7'd1 : a - 7'd1;
        p = up ? (pos(a) + 1) % 32 : (pos(a) + 31) % 32;
        return 7'((p / 16) * 64 + p % 16);
    endfunction

    task automatic m_reset();
        foreach (m_mem[i]) m_mem[i] = 8'h20;
        m_ac = 0; m_inc = 1; m_d = 0; m_c = 0; m_b = 0; m_bad = 0; m_ovr = 0;
    endtask

    task automatic m_apply(input bit rs, input bit rw, input logic [7:0] d);
        if (rw) return;
        if (rs) begin
            if (in_rng(m_ac)) begin
                m_mem[pos(m_ac)] = d;
                m_ac = m_step(m_ac, m_inc);
            end
        end else if (d >= 128) begin
            m_ac = d[6:0];
            if (!in_rng(d[6:0])) m_bad = 1;
        end else if (d >= 32) begin
        end else if (d >= 16) begin
            if (!d[3]) m_ac = m_step(m_ac, d[2]);
        end else if (d >= 8) {m_d, m_c, m_b} = d[2:0];
        else if (d >= 4) m_inc = d[1];
        else if (d >= 2) m_ac = 0;
        else if (d == 1) begin
            m_ac = 0;
            m_inc = 1;
            foreach (m_mem[i]) m_mem[i] = 8'h20;
        end
    endtask

    task automatic bus(input bit rs, input bit rw, input logic [7:0] d);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1;
        repeat (4) @(posedge clk);
        #1 lcd_en = 0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit rs, input bit rw, input logic [7:0] d);
        bus(rs, rw, d);
        m_apply(rs, rw, d);
    endtask

    task automatic rd(input int a, output logic [7:0] v);
        @(posedge clk); #1 rd_addr = 5'(a);
        @(posedge clk);
        @(negedge clk) v = rd_char;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({addr_counter, entry_inc, display_on, cursor_on, blink_on, busy, cmd_strobe, overrun, bad_addr}
            !== {7'h00, 8'b1000_1000})
            $display("FAIL reset_state: got ac=%h flags=%b expected ac=00 flags=10001000", addr_counter,
                     {entry_inc, display_on, cursor_on, blink_on, busy, cmd_strobe, overrun, bad_addr});
        else n_pass++;
        n_checks++;
        if (rd_char !== 8'h20) $display("FAIL reset_rd_char: got %h expected 20", rd_char);
        else n_pass++;
        @(posedge clk); #1 reset = 0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (last_run !== 32) $display("FAIL reset_sweep_busy: got %0d cycles expected 32", last_run);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            n_checks++;
            if (v !== 8'h20) $display("FAIL reset_ram[%0d]: got %h expected 20", i, v);
            else n_pass++;
        end
    endtask

    task automatic test_init();
        int n0 = n_strobe;
        last_run = 0;
        send(0, 0, 8'h38); send(0, 0, 8'h06); send(0, 0, 8'h0C); send(0, 0, 8'h01);
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({display_on, cursor_on, blink_on, entry_inc} !== {m_d, m_c, m_b, m_inc})
            $display("FAIL init_flags: got dcbi=%b expected %b", {display_on, cursor_on, blink_on, entry_inc},
                     {m_d, m_c, m_b, m_inc});
        else n_pass++;
        n_checks++;
        if (addr_counter !== m_ac) $display("FAIL init_ac: got %h expected %h", addr_counter, m_ac);
        else n_pass++;
        n_checks++;
        if (last_run !== 32) $display("FAIL clear_busy: got %0d cycles expected 32", last_run);
        else n_pass++;
        n_checks++;
        if (n_strobe - n0 !== 4) $display("FAIL init_strobes: got %0d expected 4", n_strobe - n0);
        else n_pass++;
    endtask

    task automatic test_data();
        logic [8*16-1:0] s = "INGRESA USUARIO ";
        logic [7:0] v;
        for (int i = 0; i < 16; i++) send(1, 0, s[8*(15-i) +: 8]);
        n_checks++;
        if (addr_counter !== m_ac) $display("FAIL data_ac: got %h expected %h", addr_counter, m_ac);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            rd(i, v);
            n_checks++;
            if (v !== m_mem[i]) $display("FAIL data_ram[%0d]: got %h expected %h", i, v, m_mem[i]);
            else n_pass++;
        end
    endtask

    task automatic test_line2();
        logic [7:0] v;
        send(0, 0, 8'hC0); send(1, 0, 8'h37);
        n_checks++;
        if (addr_counter !== m_ac) $display("FAIL line2_ac: got %h expected %h", addr_counter, m_ac);
        else n_pass++;
        rd(16, v);
        n_checks++;
        if (v !== m_mem[16]) $display("FAIL line2_ram16: got %h expected %h", v, m_mem[16]);
        else n_pass++;
        send(0, 0, 8'h04); send(0, 0, 8'h80); send(1, 0, 8'h41);
        n_checks++;
        if ({entry_inc, addr_counter} !== {m_inc, m_ac})
            $display("FAIL dec_wrap_ac: got inc=%b ac=%h expected inc=%b ac=%h", entry_inc, addr_counter, m_inc, m_ac);
        else n_pass++;
        rd(0, v);
        n_checks++;
        if (v !== m_mem[0]) $display("FAIL dec_ram0: got %h expected %h", v, m_mem[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] v, d;
        int n0 = n_strobe, exp_n = 0, kind;
        bit rs;
        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 4));
            d = 8'($urandom_range(0, 255));
            if (kind <= 1) begin
                send(1, 0, d);
                exp_n++;
            end else if (kind == 2) begin
                if (d == 8'h01) d = 8'h00;
                send(0, 0, d);
                exp_n++;
            end else if (kind == 3) begin
                send(0, 0, {1'b1, d[0], 2'b00, d[4:1]});
                exp_n++;
            end else begin
                rs = 1'($urandom_range(0, 1));
                send(rs, 1, d);
            end
            n_checks++;
            if (addr_counter !== m_ac) $display("FAIL rand_ac[%0d]: got %h expected %h", k, addr_counter, m_ac);
            else n_pass++;
        end
        n_checks++;
        if (n_strobe - n0 !== exp_n) $display("FAIL rand_strobes: got %0d expected %0d", n_strobe - n0, exp_n);
        else n_pass++;
        n_checks++;
        if ({display_on, cursor_on, blink_on, entry_inc, bad_addr, overrun} !== {m_d, m_c, m_b, m_inc, m_bad, m_ovr})
            $display("FAIL rand_flags: got %b expected %b", {display_on, cursor_on, blink_on, entry_inc, bad_addr, overrun},
                     {m_d, m_c, m_b, m_inc, m_bad, m_ovr});
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            n_checks++;
            if (v !== m_mem[i]) $display("FAIL rand_ram[%0d]: got %h expected %h", i, v, m_mem[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        send(0, 0, 8'h01);
        bus(1, 0, 8'h5A);
        m_ovr = 1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({overrun, busy, addr_counter} !== {m_ovr, 1'b0, m_ac})
            $display("FAIL overrun: got ovr=%b busy=%b ac=%h expected ovr=%b busy=0 ac=%h", overrun, busy, addr_counter,
                     m_ovr, m_ac);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            n_checks++;
            if (v !== m_mem[i]) $display("FAIL overrun_ram[%0d]: got %h expected %h", i, v, m_mem[i]);
            else n_pass++;
        end
    endtask

    task automatic test_bad_addr();
        logic [7:0] v;
        send(0, 0, 8'h90); send(1, 0, 8'h58);
        n_checks++;
        if ({bad_addr, addr_counter} !== {m_bad, m_ac})
            $display("FAIL bad_addr: got bad=%b ac=%h expected bad=%b ac=%h", bad_addr, addr_counter, m_bad, m_ac);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            n_checks++;
            if (v !== m_mem[i]) $display("FAIL bad_ram[%0d]: got %h expected %h", i, v, m_mem[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        send(0, 0, 8'h0F); send(0, 0, 8'h81); send(1, 0, 8'h51); send(0, 0, 8'h01);
        last_run = 0;
        repeat (10) @(posedge clk);
        #1 reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        m_reset();
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (last_run !== 32) $display("FAIL midreset_busy: got %0d cycles expected 32", last_run);
        else n_pass++;
        n_checks++;
        if ({addr_counter, display_on, cursor_on, blink_on, entry_inc, bad_addr, overrun}
            !== {m_ac, m_d, m_c, m_b, m_inc, m_bad, m_ovr})
            $display("FAIL midreset_state: got ac=%h flags=%b expected ac=%h flags=%b", addr_counter,
                     {display_on, cursor_on, blink_on, entry_inc, bad_addr, overrun}, m_ac,
                     {m_d, m_c, m_b, m_inc, m_bad, m_ovr});
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            n_checks++;
            if (v !== m_mem[i]) $display("FAIL midreset_ram[%0d]: got %h expected %h", i, v, m_mem[i]);
            else n_pass++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_data();
        test_line2();
        test_random();
        test_overrun();
        test_bad_addr();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
